mem_access_sequencer: RTL and testbench

- Sequences the 5-stage MIPS pipeline's IF and MEM accesses onto one shared single-port RAM.
- Each pipeline step runs the pending MEM-stage access first, then the IF fetch.
- Holds the pipeline frozen until both accesses complete, then releases it for exactly one cycle so every stage register advances.
- Sits between IF_stage/MEM_stage and the unified memory. Its freeze output drives the enables of all stage registers.

---
 rtl/mem_access_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Sequences the pipeline's MEM-stage access and then the IF fetch onto one shared
// single-port RAM, freezing the pipeline until both complete.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_instr,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              freeze,
    output logic [1:0]        err
);

    localparam int unsigned     CNT_W   = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_MEM_ACC, S_IF_ACC, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_wr, r_if_req;
    logic [ADDR_W-1:0]   r_maddr, r_iaddr;
    logic [DATA_W-1:0]   r_wdata;

    logic                r_ram_en, w_ram_en;
    logic                r_ram_we, w_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata, w_ram_wdata;
    logic [DATA_W-1:0]   r_if_instr, w_if_instr;
    logic [DATA_W-1:0]   r_mem_rdata, w_mem_rdata;
    logic                r_freeze, w_freeze;
    logic [1:0]          r_err, w_err;

    // An access is live only while the strobe is up; this also masks the gap cycle.
    logic w_ready, w_timeout, w_acc_end;
    assign w_ready   = r_ram_en && ram_ready;
    assign w_timeout = r_ram_en && !ram_ready && (r_cnt == TO_LAST);
    assign w_acc_end = w_ready || w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_rd_en || mem_wr_en) w_state_nxt = S_MEM_ACC;
                else if (if_req)            w_state_nxt = S_IF_ACC;
                else                        w_state_nxt = S_DONE;
            end
            S_MEM_ACC: if (w_acc_end) w_state_nxt = r_if_req ? S_IF_ACC : S_DONE;
            S_IF_ACC:  if (w_acc_end) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_ram_addr;
        w_ram_wdata = r_ram_wdata;
        w_freeze    = 1'b1;
        w_if_instr  = r_if_instr;
        w_mem_rdata = r_mem_rdata;
        w_err       = r_err;
        w_cnt       = r_cnt;

        if (r_state == S_IDLE && mem_rd_en && mem_wr_en) w_err[1] = 1'b1;
        if (w_timeout) w_err[0] = 1'b1;

        if (w_state_nxt != r_state)       w_cnt = '0;
        else if (r_ram_en && !ram_ready)  w_cnt = r_cnt + CNT_W'(1);

        if (r_state == S_MEM_ACC && w_ready && !r_wr) w_mem_rdata = ram_rdata;
        if (r_state == S_IF_ACC && w_ready)           w_if_instr  = ram_rdata;

        // Address/data come straight from the ports on the sampling edge, else from holds.
        case (w_state_nxt)
            S_MEM_ACC: begin
                w_ram_en    = 1'b1;
                w_ram_we    = (r_state == S_IDLE) ? mem_wr_en : r_wr;
                w_ram_addr  = (r_state == S_IDLE) ? mem_addr  : r_maddr;
                w_ram_wdata = (r_state == S_IDLE) ? mem_wdata : r_wdata;
            end
            S_IF_ACC: begin
                w_ram_en   = (r_state != S_MEM_ACC);
                w_ram_addr = (r_state == S_IDLE) ? if_addr : r_iaddr;
            end
            S_DONE:  w_freeze = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_freeze    <= 1'b1;
            r_if_instr  <= '0;
            r_mem_rdata <= '0;
            r_err       <= '0;
            r_cnt       <= '0;
        end else begin
            r_ram_en    <= w_ram_en;
            r_ram_we    <= w_ram_we;
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
            r_freeze    <= w_freeze;
            r_if_instr  <= w_if_instr;
            r_mem_rdata <= w_mem_rdata;
            r_err       <= w_err;
            r_cnt       <= w_cnt;
        end
    end

    // Request holding registers: captured once per step in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr     <= 1'b0;
            r_if_req <= 1'b0;
            r_maddr  <= '0;
            r_iaddr  <= '0;
            r_wdata  <= '0;
        end else if (r_state == S_IDLE) begin
            r_wr     <= mem_wr_en;
            r_if_req <= if_req;
            r_maddr  <= mem_addr;
            r_iaddr  <= if_addr;
            r_wdata  <= mem_wdata;
        end
    end

    assign if_instr  = r_if_instr;
    assign mem_rdata = r_mem_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign freeze    = r_freeze;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench: a responsive RAM plus a step-level reference model of
// access order, step latency, captured data and sticky error flags.
module tb_mem_access_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, mem_rd_en, mem_wr_en, ram_ready;
    logic [AW-1:0] if_addr, mem_addr, ram_addr;
    logic [DW-1:0] if_instr, mem_wdata, mem_rdata, ram_wdata, ram_rdata;
    logic          ram_en, ram_we, freeze;
    logic [1:0]    err;

    always #5 clk = ~clk;

    mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .freeze(freeze), .err(err)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] mem [bit [31:0]];
    logic [31:0] exp_rdata, exp_instr;
    logic [1:0]  exp_err;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        if_req    = 1'($urandom);
        mem_rd_en = 1'($urandom);
        mem_wr_en = 1'($urandom);
        if_addr   = $urandom;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
    endtask

    // Asserted at a negedge, checked 7 ns later (across a rising edge), released at a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        scramble_inputs();
        ram_ready = 1'($urandom);
        ram_rdata = $urandom;
        #7;
        check("rst_freeze", freeze, 1);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_err", err, 0);
        exp_rdata = '0;
        exp_instr = '0;
        exp_err   = '0;
        @(negedge clk);
        rst       = 1'b1;
        ram_ready = 1'b0;
    endtask

    // One pipeline step; entered and left at the negedge of an IDLE cycle.
    // lm/lif: wait cycles before ready (>= TO never answers). abort_at: cycle to assert reset (0 = none).
    task automatic run_step(input logic rd, input logic wr, input logic [31:0] maddr,
                            input logic [31:0] wdata, input logic ifreq, input logic [31:0] iaddr,
                            input int lm, input int lif, input int abort_at);
        logic [31:0] a_addr[2];
        logic [31:0] a_wd[2];
        logic        a_we[2];
        int          a_l[2];
        int          en_cnt[2];
        int          n_exp, idx, k, c, lat_obs, lat_exp;
        logic        has_m, m_to, i_to, prev_en, rdy;
        logic [31:0] e_rdata, e_instr;
        logic [1:0]  e_err;

        has_m = rd | wr;
        m_to  = has_m && (lm >= TO);
        i_to  = ifreq && (lif >= TO);
        n_exp = 0;
        if (has_m) begin
            a_addr[n_exp] = maddr; a_we[n_exp] = wr; a_wd[n_exp] = wdata; a_l[n_exp] = lm;
            n_exp++;
        end
        if (ifreq) begin
            a_addr[n_exp] = iaddr; a_we[n_exp] = 1'b0; a_wd[n_exp] = '0; a_l[n_exp] = lif;
            n_exp++;
        end
        e_rdata = (has_m && !wr && !m_to) ? mem_rd(maddr) : exp_rdata;
        e_instr = exp_instr;
        if (ifreq && !i_to)
            e_instr = (has_m && wr && !m_to && iaddr == maddr) ? wdata : mem_rd(iaddr);
        e_err = exp_err | {rd & wr, m_to | i_to};
        // IDLE + DONE, each access lasts (wait + 1) cycles, plus a strobe gap between two accesses
        lat_exp = 2 + (n_exp == 2 ? 1 : 0);
        for (int i = 0; i < n_exp; i++) lat_exp += 1 + ((a_l[i] >= TO) ? TO - 1 : a_l[i]);

        mem_rd_en = rd; mem_wr_en = wr; mem_addr = maddr; mem_wdata = wdata;
        if_req = ifreq; if_addr = iaddr;
        ram_ready = 1'($urandom);
        ram_rdata = $urandom;
        check("idle_freeze", freeze, 1);
        check("idle_ram_en", ram_en, 0);

        idx = -1; k = 0; lat_obs = 0; prev_en = 1'b0;
        en_cnt[0] = 0; en_cnt[1] = 0;
        for (c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check("abort_ram_en", ram_en, 0);
                check("abort_freeze", freeze, 1);
                check("abort_if_instr", if_instr, 0);
                check("abort_mem_rdata", mem_rdata, 0);
                check("abort_err", err, 0);
                exp_rdata = '0; exp_instr = '0; exp_err = '0;
                ram_ready = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            scramble_inputs();
            if (!freeze) begin
                lat_obs   = c;
                ram_ready = 1'($urandom);
                ram_rdata = $urandom;
                break;
            end
            rdy = 1'b0;
            if (ram_en) begin
                if (!prev_en) begin idx++; k = 0; end
                else k++;
                if (idx < n_exp) begin
                    en_cnt[idx]++;
                    check("acc_addr", ram_addr, a_addr[idx]);
                    check("acc_we", ram_we, a_we[idx]);
                    if (a_we[idx]) check("acc_wdata", ram_wdata, a_wd[idx]);
                    rdy = (a_l[idx] < TO) && (k == a_l[idx]);
                end
            end
            ram_ready = rdy;
            ram_rdata = rdy ? mem_rd(ram_addr) : $urandom;
            if (rdy && ram_we) mem[ram_addr] = ram_wdata;
            prev_en = ram_en;
        end

        check("step_done_in_bound", (lat_obs != 0), 1);
        check("latency", lat_obs, lat_exp);
        check("access_count", idx + 1, n_exp);
        for (int i = 0; i < n_exp; i++)
            check("access_len", en_cnt[i], 1 + ((a_l[i] >= TO) ? TO - 1 : a_l[i]));
        check("mem_rdata", mem_rdata, e_rdata);
        check("if_instr", if_instr, e_instr);
        check("err", err, e_err);
        exp_rdata = e_rdata;
        exp_instr = e_instr;
        exp_err   = e_err;
        @(negedge clk);
        ram_ready = 1'b0;
    endtask

    initial begin
        int lsel[2];
        int lv[2];
        rst = 1'b0;
        scramble_inputs();
        ram_ready = 1'b0;
        ram_rdata = '0;
        exp_rdata = '0; exp_instr = '0; exp_err = '0;

        do_reset();

        mem[32'h4] = 32'h2001_000A;
        run_step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 0, 1, 0);

        mem[32'h100] = 32'hDEAD_BEEF;
        mem[32'h8]   = 32'h8C22_0000;
        run_step(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h8, 0, 0, 0);

        run_step(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, 2, 0, 0);
        run_step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1, 0, 0);
        run_step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0);

        run_step(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hC, 99, 0, 0);
        do_reset();
        run_step(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'h10, TO - 1, 0, 0);

        run_step(1'b1, 1'b1, 32'h48, 32'hCAFE_F00D, 1'b1, 32'h48, 0, 3, 0);
        run_step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h14, 0, 99, 5);

        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 2; j++) begin
                lsel[j] = int'($urandom_range(0, 9));
                lv[j] = (lsel[j] < 7) ? int'($urandom_range(0, 3)) :
                        (lsel[j] == 7) ? int'(TO) - 1 : (lsel[j] == 8) ? int'(TO) : 20;
            end
            run_step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                     32'($urandom_range(0, 15)) << 2, $urandom,
                     1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 15)) << 2,
                     lv[0], lv[1], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
